// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the trap sequencer.
package trap_ctrl_pkg;

  // Exception codes (mcause[4:0]) that the pipeline can raise at write-back.
  typedef enum logic [4:0] {
    INSTR_MISALIGNED = 5'd0,
    ILLEGAL_INSTR    = 5'd2,
    BREAKPOINT       = 5'd3,
    LOAD_MISALIGNED  = 5'd4,
    STORE_MISALIGNED = 5'd6,
    ECALL_M          = 5'd11
  } exc_cause_e;

  // Sequencer phases.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } trap_state_e;

  // What started the current sequence: decides where the redirect goes.
  typedef enum logic {
    TRAP = 1'b0,
    MRET = 1'b1
  } trap_kind_e;

  // Two cycles cover an mtvec write plus the registered handler address.
  localparam int TRAP_FLUSH_CYCLES_DEFAULT = 2;

  // Fetch targets are word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Write-back, CSR and fetch-redirect signals seen by the trap sequencer.
// TRAP_CTRL_DOUBLE_FAULT_EN adds the sticky double_fault_o flag.
interface trap_ctrl_if;
  import trap_ctrl_pkg::*;

  logic        wb_valid_i;
  logic        wb_exc_valid_i;
  exc_cause_e  wb_exc_cause_i;
  logic [31:0] wb_pc_i;
  logic        wb_mret_i;
  logic [31:0] trap_handler_addr_i;
  logic [31:0] csr_mepc_i;
  logic        fetch_ready_i;

  logic        trap_valid_o;
  logic [31:0] trap_pc_o;
  logic [31:0] trap_mcause_o;
  logic        flush_o;
  logic        stall_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
`ifdef TRAP_CTRL_DOUBLE_FAULT_EN
  logic        double_fault_o;
`endif

  // Pipeline / CSR file / fetch side: drives events, consumes the redirect.
  modport master (
    output wb_valid_i, wb_exc_valid_i, wb_exc_cause_i, wb_pc_i, wb_mret_i,
    output trap_handler_addr_i, csr_mepc_i, fetch_ready_i,
    input  trap_valid_o, trap_pc_o, trap_mcause_o, flush_o, stall_o,
    input  redirect_valid_o, redirect_pc_o
`ifdef TRAP_CTRL_DOUBLE_FAULT_EN
    , input double_fault_o
`endif
  );

  // Trap sequencer side.
  modport slave (
    input  wb_valid_i, wb_exc_valid_i, wb_exc_cause_i, wb_pc_i, wb_mret_i,
    input  trap_handler_addr_i, csr_mepc_i, fetch_ready_i,
    output trap_valid_o, trap_pc_o, trap_mcause_o, flush_o, stall_o,
    output redirect_valid_o, redirect_pc_o
`ifdef TRAP_CTRL_DOUBLE_FAULT_EN
    , output double_fault_o
`endif
  );

endinterface

// File: rtl/trap_ctrl.sv
// Trap sequencer: commits a trap to the CSR file at write-back, flushes the
// pipeline until the registered handler address is settled, then issues one
// fetch redirect (handler for traps, mepc for MRET).
// Optional macro TRAP_CTRL_DOUBLE_FAULT_EN adds a sticky double-fault flag.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = TRAP_FLUSH_CYCLES_DEFAULT,  // >= 2
  parameter int CNT_W        = 3                          // 2**CNT_W > FLUSH_CYCLES
) (
  input logic        clk_i,
  input logic        rst_ni,
  trap_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE     = 2'(IDLE);
  localparam logic [1:0] ST_FLUSH    = 2'(FLUSH);
  localparam logic [1:0] ST_REDIRECT = 2'(REDIRECT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  trap_kind_e       kind_reg, kind_next;
  logic [31:0]      target_reg, target_next;

  logic idle;
  logic trap_ev;
  logic mret_ev;
  logic handshake;

  // Events only count in IDLE; gating with rst_ni keeps the combinational
  // outputs at zero while reset is held.
  assign idle      = (state_reg == ST_IDLE);
  assign trap_ev   = rst_ni & idle & bus.wb_valid_i & bus.wb_exc_valid_i;
  assign mret_ev   = rst_ni & idle & bus.wb_valid_i & bus.wb_mret_i & ~bus.wb_exc_valid_i;
  assign handshake = (state_reg == ST_REDIRECT) & bus.fetch_ready_i;

  // Next-state, flush counter and redirect target selection.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    kind_next   = kind_reg;
    target_next = target_reg;
    case (state_reg)
      ST_IDLE: begin
        if (trap_ev) begin
          state_next = ST_FLUSH;
          cnt_next   = CNT_LOAD;
          kind_next  = TRAP;
        end else if (mret_ev) begin
          state_next  = ST_FLUSH;
          cnt_next    = CNT_LOAD;
          kind_next   = MRET;
          target_next = align_word(bus.csr_mepc_i);
        end
      end
      ST_FLUSH: begin
        if (cnt_reg == '0) begin
          state_next = ST_REDIRECT;
          // Sample the handler address as late as possible so a preceding
          // mtvec write has propagated through the CSR file.
          if (kind_reg == TRAP) begin
            target_next = align_word(bus.trap_handler_addr_i);
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_REDIRECT: begin
        if (bus.fetch_ready_i) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Sequencer state registers; reset abandons any sequence in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      kind_reg   <= TRAP;
      target_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      kind_reg   <= kind_next;
      target_reg <= target_next;
    end
  end

  assign bus.trap_valid_o     = trap_ev;
  assign bus.trap_pc_o        = trap_ev ? bus.wb_pc_i : 32'd0;
  assign bus.trap_mcause_o    = trap_ev ? {27'd0, 5'(bus.wb_exc_cause_i)} : 32'd0;
  assign bus.flush_o          = trap_ev | mret_ev | (state_reg == ST_FLUSH);
  assign bus.stall_o          = (state_reg == ST_FLUSH) | (state_reg == ST_REDIRECT);
  assign bus.redirect_valid_o = (state_reg == ST_REDIRECT);
  assign bus.redirect_pc_o    = (state_reg == ST_REDIRECT) ? target_reg : 32'd0;

`ifdef TRAP_CTRL_DOUBLE_FAULT_EN
  logic in_handler_reg;
  logic double_fault_reg;

  // Track handler residency and flag a trap taken while already inside one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_handler_reg   <= 1'b0;
      double_fault_reg <= 1'b0;
    end else begin
      if (handshake && kind_reg == TRAP) begin
        in_handler_reg <= 1'b1;
      end else if (handshake && kind_reg == MRET) begin
        in_handler_reg <= 1'b0;
      end
      if (trap_ev && in_handler_reg) begin
        double_fault_reg <= 1'b1;
      end
    end
  end

  assign bus.double_fault_o = double_fault_reg;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

  // The pipeline is flushed while busy, so no instruction may reach WB.
  property p_no_wb_while_busy;
    @(posedge clk_i) disable iff (!rst_ni) (state_reg != ST_IDLE) |-> !bus.wb_valid_i;
  endproperty
  a_no_wb_while_busy: assert property (p_no_wb_while_busy);

endmodule
